// File: rtl/alu_mc.sv
// Multi-cycle handshaked ALU: 8-op map, modulo via an iterative restoring divider.
// Define ALU_FLAGS_EN to add the {dz, carry, zero} flags port and its registers.
module alu_mc #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic [2:0]       ctrl,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] y
`ifdef ALU_FLAGS_EN
    ,
    output logic [2:0]       flags
`endif
);

    localparam int CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] y_q, y_d;
    logic [WIDTH-1:0] rem_q, rem_d;
    logic [WIDTH-1:0] quo_q, quo_d;
    logic [WIDTH-1:0] b_q, b_d;
    logic [CW-1:0]    cnt_q, cnt_d;

    logic [WIDTH-1:0] op_res;
    logic [WIDTH:0]   rem_shift;
    logic [WIDTH:0]   rem_diff;
    logic [WIDTH-1:0] rem_step;
    logic [WIDTH-1:0] quo_step;
    logic             accept;

`ifdef ALU_FLAGS_EN
    logic [2:0] flags_q, flags_d;
    logic       op_carry;
`endif

    // rst_n gates in_ready so nothing is accepted while reset is held.
    assign in_ready  = (state_q == IDLE) && rst_n;
    assign accept    = in_valid && in_ready;
    assign out_valid = (state_q == DONE);
    assign y         = y_q;

    always_comb begin
        op_res = A;
        case (ctrl)
            3'b000:  op_res = A + B;
            3'b010:  op_res = A - B;
            3'b011:  op_res = B - A;
            3'b100:  op_res = {A[WIDTH-2:0], 1'b0};
            3'b101:  op_res = A ^ B;
            3'b110:  op_res = A & B;
            3'b111:  op_res = A | B;
            default: op_res = A;
        endcase
    end

`ifdef ALU_FLAGS_EN
    // Add carry-out shows up as the truncated sum wrapping below A.
    always_comb begin
        op_carry = 1'b0;
        case (ctrl)
            3'b000:  op_carry = (op_res < A);
            3'b010:  op_carry = (A < B);
            3'b011:  op_carry = (B < A);
            3'b100:  op_carry = A[WIDTH-1];
            default: op_carry = 1'b0;
        endcase
    end
    assign flags = flags_q;
`endif

    // One restoring step: a negative trial difference leaves its MSB set.
    always_comb begin
        rem_shift = {rem_q, quo_q[WIDTH-1]};
        rem_diff  = rem_shift - {1'b0, b_q};
        if (!rem_diff[WIDTH]) begin
            rem_step = rem_diff[WIDTH-1:0];
            quo_step = {quo_q[WIDTH-2:0], 1'b1};
        end else begin
            rem_step = rem_shift[WIDTH-1:0];
            quo_step = {quo_q[WIDTH-2:0], 1'b0};
        end
    end

    always_comb begin
        state_d = state_q;
        y_d     = y_q;
        rem_d   = rem_q;
        quo_d   = quo_q;
        b_d     = b_q;
        cnt_d   = cnt_q;
`ifdef ALU_FLAGS_EN
        flags_d = flags_q;
`endif
        case (state_q)
            IDLE: begin
                if (accept) begin
                    b_d = B;
                    if (ctrl == 3'b001 && B != '0) begin
                        rem_d   = '0;
                        quo_d   = A;
                        cnt_d   = CW'(WIDTH - 1);
                        state_d = CALC;
                    end else begin
                        y_d     = op_res;
                        state_d = DONE;
`ifdef ALU_FLAGS_EN
                        flags_d = {ctrl == 3'b001, op_carry, op_res == '0};
`endif
                    end
                end
            end
            CALC: begin
                rem_d = rem_step;
                quo_d = quo_step;
                if (cnt_q == '0) begin
                    y_d     = rem_step;
                    state_d = DONE;
`ifdef ALU_FLAGS_EN
                    flags_d = {2'b00, rem_step == '0};
`endif
                end else begin
                    cnt_d = cnt_q - CW'(1);
                end
            end
            DONE: begin
                if (out_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= IDLE;
            y_q     <= '0;
            rem_q   <= '0;
            quo_q   <= '0;
            b_q     <= '0;
            cnt_q   <= '0;
`ifdef ALU_FLAGS_EN
            flags_q <= '0;
`endif
        end else begin
            state_q <= state_d;
            y_q     <= y_d;
            rem_q   <= rem_d;
            quo_q   <= quo_d;
            b_q     <= b_d;
            cnt_q   <= cnt_d;
`ifdef ALU_FLAGS_EN
            flags_q <= flags_d;
`endif
        end
    end

endmodule

// File: tb/tb_alu_mc.sv
// Bench for alu_mc: 8-bit and 16-bit instances, queued expected results checked by monitors.
// Flag checks are compiled in only when ALU_FLAGS_EN is defined.
module tb_alu_mc;

    logic clk;
    logic rst_n;

    logic        in_valid8, in_ready8, out_valid8, out_ready8;
    logic [7:0]  a8, b8, y8;
    logic [2:0]  ctrl8;
    logic        in_valid16, in_ready16, out_valid16, out_ready16;
    logic [15:0] a16, b16, y16;
    logic [2:0]  ctrl16;
`ifdef ALU_FLAGS_EN
    logic [2:0]  flags8, flags16;
`endif

    int compared   = 0;
    int mismatched = 0;

    logic [10:0] exp_q8[$];
    logic [18:0] exp_q16[$];

    alu_mc #(.WIDTH(8)) u_alu8 (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid8), .in_ready(in_ready8),
        .A(a8), .B(b8), .ctrl(ctrl8),
        .out_valid(out_valid8), .out_ready(out_ready8),
        .y(y8)
`ifdef ALU_FLAGS_EN
        , .flags(flags8)
`endif
    );

    alu_mc #(.WIDTH(16)) u_alu16 (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid16), .in_ready(in_ready16),
        .A(a16), .B(b16), .ctrl(ctrl16),
        .out_valid(out_valid16), .out_ready(out_ready16),
        .y(y16)
`ifdef ALU_FLAGS_EN
        , .flags(flags16)
`endif
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        compared++;
        if (act !== exp) begin
            mismatched++;
            $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h)", name, act, act, exp, exp);
        end
    endtask

    // monitors
    always @(negedge clk) begin
        if (rst_n && out_valid8 && out_ready8) begin
            if (exp_q8.size() == 0) begin
                chk("unexpected_out_valid8", 32'd1, 32'd0);
            end else begin
                logic [10:0] e;
                e = exp_q8.pop_front();
                chk("y8", {24'd0, y8}, {24'd0, e[7:0]});
`ifdef ALU_FLAGS_EN
                chk("flags8", {29'd0, flags8}, {29'd0, e[10:8]});
`endif
            end
        end
    end

    always @(negedge clk) begin
        if (rst_n && out_valid16 && out_ready16) begin
            if (exp_q16.size() == 0) begin
                chk("unexpected_out_valid16", 32'd1, 32'd0);
            end else begin
                logic [18:0] e;
                e = exp_q16.pop_front();
                chk("y16", {16'd0, y16}, {16'd0, e[15:0]});
`ifdef ALU_FLAGS_EN
                chk("flags16", {29'd0, flags16}, {29'd0, e[18:16]});
`endif
            end
        end
    end

    // driver: present operands, wait for acceptance, queue the expected result.
    // Returns 1 time unit after the accepting edge.
    task automatic send(input bit w16, input logic [15:0] a, input logic [15:0] b,
                        input logic [2:0] op, input logic [15:0] ey, input logic [2:0] ef,
                        input bit push);
        int n;
        if (w16) begin
            a16 = a; b16 = b; ctrl16 = op; in_valid16 = 1'b1;
        end else begin
            a8 = a[7:0]; b8 = b[7:0]; ctrl8 = op; in_valid8 = 1'b1;
        end
        n = 0;
        @(negedge clk);
        while (!(w16 ? in_ready16 : in_ready8) && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (n >= 100) chk("accept_timeout", 32'd0, 32'd1);
        if (push) begin
            if (w16) exp_q16.push_back({ef, ey});
            else     exp_q8.push_back({ef, ey[7:0]});
        end
        @(posedge clk);
        #1;
        in_valid8  = 1'b0;
        in_valid16 = 1'b0;
    endtask

    // Counts cycles after accept until out_valid and until in_ready returns (out_ready held 1).
    task automatic check_latency(input bit w16, input int lat, input string name);
        int n, lows, seen_at;
        n = 0; lows = 0; seen_at = -1;
        while (n < 200) begin
            @(negedge clk);
            n++;
            if (!(w16 ? in_ready16 : in_ready8)) lows++;
            if ((w16 ? out_valid16 : out_valid8) && seen_at < 0) seen_at = n;
            if (w16 ? in_ready16 : in_ready8) break;
        end
        chk({name, "_latency"}, seen_at, lat);
        chk({name, "_in_ready_low"}, lows, lat);
        @(posedge clk);
        #1;
    endtask

    task automatic op(input bit w16, input logic [15:0] a, input logic [15:0] b,
                      input logic [2:0] c, input logic [15:0] ey, input logic [2:0] ef,
                      input int lat, input string name);
        send(w16, a, b, c, ey, ef, 1'b1);
        check_latency(w16, lat, name);
    endtask

    initial begin
        int quiet;
        rst_n = 1'b0;
        in_valid8 = 0; in_valid16 = 0; out_ready8 = 1; out_ready16 = 1;
        a8 = 0; b8 = 0; ctrl8 = 0; a16 = 0; b16 = 0; ctrl16 = 0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_in_ready8", {31'd0, in_ready8}, 32'd0);
        chk("rst_out_valid8", {31'd0, out_valid8}, 32'd0);
        @(posedge clk);
        #1 rst_n = 1'b1;
        @(negedge clk);
        chk("post_rst_in_ready8", {31'd0, in_ready8}, 32'd1);
        chk("post_rst_in_ready16", {31'd0, in_ready16}, 32'd1);
        chk("post_rst_y8", {24'd0, y8}, 32'd0);
        chk("post_rst_y16", {16'd0, y16}, 32'd0);
        chk("post_rst_out_valid16", {31'd0, out_valid16}, 32'd0);
`ifdef ALU_FLAGS_EN
        chk("post_rst_flags8", {29'd0, flags8}, 32'd0);
`endif
        @(posedge clk);
        #1;

        // directed vectors, 8-bit
        op(0, 61,   6,   3'b000, 67,   3'b000, 1, "add_61_6");
        op(0, 61,   6,   3'b001, 1,    3'b000, 9, "mod_61_6");
        op(0, 255,  255, 3'b001, 0,    3'b001, 9, "mod_255_255");
        op(0, 15,   0,   3'b001, 15,   3'b100, 1, "mod_by_zero");
        op(0, 200,  7,   3'b001, 4,    3'b000, 9, "mod_200_7");
        op(0, 5,    9,   3'b001, 5,    3'b000, 9, "mod_5_9");
        op(0, 255,  1,   3'b001, 0,    3'b001, 9, "mod_255_1");
        op(0, 200,  100, 3'b000, 44,   3'b010, 1, "add_carry");
        op(0, 128,  128, 3'b000, 0,    3'b011, 1, "add_wrap_zero");
        op(0, 61,   6,   3'b010, 55,   3'b000, 1, "sub_ab");
        op(0, 6,    61,  3'b010, 201,  3'b010, 1, "sub_ab_borrow");
        op(0, 6,    61,  3'b011, 55,   3'b000, 1, "sub_ba");
        op(0, 8'h81, 0,  3'b100, 8'h02, 3'b010, 1, "shl_carry");
        op(0, 8'h80, 0,  3'b100, 8'h00, 3'b011, 1, "shl_zero");
        op(0, 8'h35, 0,  3'b100, 8'h6A, 3'b000, 1, "shl_plain");
        op(0, 8'hF0, 8'h3C, 3'b101, 8'hCC, 3'b000, 1, "xor");
        op(0, 8'hF0, 8'h0F, 3'b110, 8'h00, 3'b001, 1, "and_zero");
        op(0, 8'hA0, 8'h05, 3'b111, 8'hA5, 3'b000, 1, "or");

        // back-pressure on B-A with borrow
        out_ready8 = 1'b0;
        send(0, 15, 1, 3'b011, 242, 3'b010, 1'b1);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("bp_out_valid", {31'd0, out_valid8}, 32'd1);
            chk("bp_y_stable", {24'd0, y8}, 32'd242);
            chk("bp_in_ready", {31'd0, in_ready8}, 32'd0);
        end
        @(posedge clk);
        #1 out_ready8 = 1'b1;
        @(negedge clk);
        @(posedge clk);
        #1;
        @(negedge clk);
        chk("bp_release_in_ready", {31'd0, in_ready8}, 32'd1);
        @(posedge clk);
        #1;

        // reset on the 4th CALC cycle of 61 % 6; the result must never appear
        send(0, 61, 6, 3'b001, 1, 3'b000, 1'b0);
        repeat (3) begin
            @(posedge clk);
            #1;
        end
        rst_n = 1'b0;
        @(negedge clk);
        chk("midcalc_rst_in_ready", {31'd0, in_ready8}, 32'd0);
        @(posedge clk);
        #1 rst_n = 1'b1;
        @(negedge clk);
        chk("midcalc_out_valid", {31'd0, out_valid8}, 32'd0);
        chk("midcalc_y", {24'd0, y8}, 32'd0);
        chk("midcalc_in_ready", {31'd0, in_ready8}, 32'd1);
        quiet = 0;
        for (int i = 0; i < 15; i++) begin
            @(negedge clk);
            if (out_valid8) quiet++;
        end
        chk("midcalc_no_result", quiet, 0);
        @(posedge clk);
        #1;

        // 16-bit instance
        op(1, 16'hFFFF, 16'h0001, 3'b000, 16'h0000, 3'b011, 1,  "add16_wrap");
        op(1, 16'hFFFF, 16'h0001, 3'b001, 16'h0000, 3'b001, 17, "mod16_by_1");
        op(1, 16'd50000, 16'd300, 3'b001, 16'd200,  3'b000, 17, "mod16_50000_300");
        op(1, 16'h1234, 16'h0F0F, 3'b111, 16'h1F3F, 3'b000, 1,  "or16");

        repeat (4) @(posedge clk);
        chk("queue8_drained", exp_q8.size(), 0);
        chk("queue16_drained", exp_q16.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

    initial begin
        #200000;
        chk("global_timeout", 32'd1, 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
